// File: rtl/drawbridge_seq_ctrl_if.sv
// Drawbridge sequencer signal bundle: sensor/acknowledge inputs towards the
// controller and barrier, alert, motor and debug outputs back to the drivers.
interface drawbridge_seq_ctrl_if #(
    parameter int CNT_W = 4
);
    logic             i_carIn;
    logic             i_carOut;
    logic             i_boatClose;
    logic             i_boatHere;
    logic             i_faultAck;
    logic [CNT_W-1:0] o_carCount;
    logic             o_hasCar;
    logic             o_carBarrier;
    logic             o_alert;
    logic             o_bridge_s;
    logic             o_motorUp;
    logic             o_motorDown;
    logic             o_fault;
    logic [2:0]       o_state;

    // Sensor/driver side that feeds the controller and watches its outputs
    modport master (
        output i_carIn, i_carOut, i_boatClose, i_boatHere, i_faultAck,
        input  o_carCount, o_hasCar, o_carBarrier, o_alert, o_bridge_s,
               o_motorUp, o_motorDown, o_fault, o_state
    );

    // Controller side
    modport slave (
        input  i_carIn, i_carOut, i_boatClose, i_boatHere, i_faultAck,
        output o_carCount, o_hasCar, o_carBarrier, o_alert, o_bridge_s,
               o_motorUp, o_motorDown, o_fault, o_state
    );
endinterface

// File: rtl/drawbridge_seq_ctrl.sv
// Drawbridge sequencer: warns road traffic, closes the barrier, waits for the
// bridge to empty (with a timeout fault), raises, holds, and lowers the bridge.
// All outputs decode registered state, so there is no input-to-output path.
module drawbridge_seq_ctrl #(
    parameter int CNT_W         = 4,
    parameter int ALERT_CYCLES  = 8,
    parameter int MOVE_CYCLES   = 16,
    parameter int CLEAR_TIMEOUT = 64
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    drawbridge_seq_ctrl_if.slave  bus
);

    localparam int MAX_AM  = (ALERT_CYCLES > MOVE_CYCLES) ? ALERT_CYCLES : MOVE_CYCLES;
    localparam int MAX_ALL = (MAX_AM > CLEAR_TIMEOUT) ? MAX_AM : CLEAR_TIMEOUT;
    localparam int TW      = $clog2(MAX_ALL + 1);

    localparam logic [TW-1:0]    ALERT_LOAD = TW'(ALERT_CYCLES);
    localparam logic [TW-1:0]    MOVE_LOAD  = TW'(MOVE_CYCLES);
    localparam logic [TW-1:0]    CLEAR_LOAD = TW'(CLEAR_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [2:0] {
        S_OPEN  = 3'd0,
        S_WARN  = 3'd1,
        S_CLEAR = 3'd2,
        S_RAISE = 3'd3,
        S_UP    = 3'd4,
        S_LOWER = 3'd5,
        S_FAULT = 3'd6
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [TW-1:0]    timer;
    logic [TW-1:0]    timer_nxt;
    logic [CNT_W-1:0] car_count;
    logic             fault;
    logic             set_fault;
    logic             boat_req;
    logic             timer_done;
    logic             barrier;
    logic             alert;
    logic             bridge_s;
    logic             motor_up;
    logic             motor_down;

    assign boat_req = bus.i_boatClose | bus.i_boatHere;

    // The timer is loaded with N on state entry, so the state expires on its
    // Nth cycle when the remaining count is 1.
    assign timer_done = (timer <= TW'(1));

    // Saturating occupancy counter; simultaneous in/out pulses cancel
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            car_count <= '0;
        end else if (bus.i_carIn && !bus.i_carOut && car_count != CNT_MAX) begin
            car_count <= car_count + CNT_W'(1);
        end else if (bus.i_carOut && !bus.i_carIn && car_count != '0) begin
            car_count <= car_count - CNT_W'(1);
        end
    end

    // State and timer registers
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= S_OPEN;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    // Sticky fault: a new timeout wins over an acknowledge, and an
    // acknowledge is ignored while the bridge is still stuck in FAULT
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            fault <= 1'b0;
        end else if (set_fault) begin
            fault <= 1'b1;
        end else if (bus.i_faultAck && state != S_FAULT) begin
            fault <= 1'b0;
        end
    end

    // Next-state, timer load/decrement and fault-set decisions
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        set_fault = 1'b0;
        case (state)
            S_OPEN: begin
                if (boat_req) begin
                    state_nxt = S_WARN;
                    timer_nxt = ALERT_LOAD;
                end
            end
            S_WARN: begin
                if (timer_done) begin
                    state_nxt = S_CLEAR;
                    timer_nxt = CLEAR_LOAD;
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end
            S_CLEAR: begin
                if (car_count == '0) begin
                    state_nxt = S_RAISE;
                    timer_nxt = MOVE_LOAD;
                end else if (timer_done) begin
                    state_nxt = S_FAULT;
                    set_fault = 1'b1;
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end
            S_FAULT: begin
                if (car_count == '0) begin
                    state_nxt = S_RAISE;
                    timer_nxt = MOVE_LOAD;
                end
            end
            S_RAISE: begin
                if (timer_done) begin
                    state_nxt = S_UP;
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end
            S_UP: begin
                if (!boat_req) begin
                    state_nxt = S_LOWER;
                    timer_nxt = MOVE_LOAD;
                end
            end
            S_LOWER: begin
                if (timer_done) begin
                    state_nxt = S_OPEN;
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end
            default: begin
                state_nxt = S_OPEN;
                timer_nxt = '0;
            end
        endcase
    end

    // Moore output decode; the unused encoding behaves like OPEN
    always_comb begin
        barrier    = 1'b0;
        alert      = 1'b0;
        bridge_s   = 1'b0;
        motor_up   = 1'b0;
        motor_down = 1'b0;
        case (state)
            S_WARN: begin
                alert = 1'b1;
            end
            S_CLEAR, S_FAULT: begin
                barrier = 1'b1;
                alert   = 1'b1;
            end
            S_RAISE: begin
                barrier  = 1'b1;
                alert    = 1'b1;
                bridge_s = 1'b1;
                motor_up = 1'b1;
            end
            S_UP: begin
                barrier  = 1'b1;
                alert    = 1'b1;
                bridge_s = 1'b1;
            end
            S_LOWER: begin
                barrier    = 1'b1;
                alert      = 1'b1;
                bridge_s   = 1'b1;
                motor_down = 1'b1;
            end
            default: begin
                barrier = 1'b0;
            end
        endcase
    end

    assign bus.o_carCount   = car_count;
    assign bus.o_hasCar     = (car_count != '0);
    assign bus.o_carBarrier = barrier;
    assign bus.o_alert      = alert;
    assign bus.o_bridge_s   = bridge_s;
    assign bus.o_motorUp    = motor_up;
    assign bus.o_motorDown  = motor_down;
    assign bus.o_fault      = fault;
    assign bus.o_state      = state;

endmodule

// File: tb/tb_drawbridge_seq_ctrl.sv
// Self-checking bench for the drawbridge sequencer: a table of counter
// vectors plus hand-written raise/lower, clearance, fault and reset sequences.
module tb_drawbridge_seq_ctrl;

    localparam int CNT_W = 3;
    localparam int VW    = CNT_W + 10;

    localparam logic [2:0] ST_O = 3'd0;
    localparam logic [2:0] ST_W = 3'd1;
    localparam logic [2:0] ST_C = 3'd2;
    localparam logic [2:0] ST_R = 3'd3;
    localparam logic [2:0] ST_U = 3'd4;
    localparam logic [2:0] ST_L = 3'd5;
    localparam logic [2:0] ST_F = 3'd6;

    typedef struct {
        logic             car_in;
        logic             car_out;
        logic             boat_close;
        logic             boat_here;
        logic             fault_ack;
        logic [2:0]       exp_state;
        logic [CNT_W-1:0] exp_count;
        logic             exp_fault;
        string            name;
    } vec_t;

    typedef struct {
        logic [2:0]       state;
        logic [CNT_W-1:0] count;
        logic             fault;
        string            name;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t exp_q[$];
    vec_t vectors[22];

    drawbridge_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();

    drawbridge_seq_ctrl #(
        .CNT_W        (CNT_W),
        .ALERT_CYCLES (4),
        .MOVE_CYCLES  (3),
        .CLEAR_TIMEOUT(10)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Moore output table {barrier, alert, bridge_s, motorUp, motorDown}
    function automatic logic [4:0] specOutputs(input logic [2:0] st);
        case (st)
            3'd1:       return 5'b01000;
            3'd2, 3'd6: return 5'b11000;
            3'd3:       return 5'b11110;
            3'd4:       return 5'b11100;
            3'd5:       return 5'b11101;
            default:    return 5'b00000;
        endcase
    endfunction

    function automatic logic [VW-1:0] actualVector();
        return {bus.o_state, bus.o_carCount, bus.o_hasCar, bus.o_carBarrier,
                bus.o_alert, bus.o_bridge_s, bus.o_motorUp, bus.o_motorDown,
                bus.o_fault};
    endfunction

    task automatic checkOutput();
        exp_t           e;
        logic [VW-1:0]  want;
        logic [VW-1:0]  got;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_empty: no expected entry queued");
        end else begin
            e    = exp_q.pop_front();
            want = {e.state, e.count, (e.count != '0), specOutputs(e.state), e.fault};
            got  = actualVector();
            if (got !== want) begin
                failures++;
                $display("[TB] FAIL %s: got {state,count,hasCar,bar,alert,bridge,up,down,fault}=%b required %b",
                         e.name, got, want);
            end
        end
        checks++;
        if (bus.o_motorUp === 1'b1 && bus.o_motorDown === 1'b1) begin
            failures++;
            $display("[TB] FAIL motor_exclusive: got up=%b down=%b required not both 1",
                     bus.o_motorUp, bus.o_motorDown);
        end
    endtask

    task automatic checkZero(input string name);
        logic [VW-1:0] got;
        got = actualVector();
        checks++;
        if (got !== '0) begin
            failures++;
            $display("[TB] FAIL %s: got outputs %b required all zero", name, got);
        end
    endtask

    // Drives one cycle of inputs, queues the expectation and checks after the edge
    task automatic applyStimulus(input logic ci, input logic co, input logic bc,
                                 input logic bh, input logic ack,
                                 input logic [2:0] es, input logic [CNT_W-1:0] ec,
                                 input logic ef, input string name);
        exp_t e;
        bus.i_carIn     = ci;
        bus.i_carOut    = co;
        bus.i_boatClose = bc;
        bus.i_boatHere  = bh;
        bus.i_faultAck  = ack;
        e.state = es;
        e.count = ec;
        e.fault = ef;
        e.name  = name;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic countUp2();
        applyStimulus(1, 0, 0, 0, 0, ST_O, 3'd1, 0, "load_car1");
        applyStimulus(1, 0, 0, 0, 0, ST_O, 3'd2, 0, "load_car2");
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;

        for (int i = 0; i < 22; i++) begin
            vectors[i].car_in     = 1'b0;
            vectors[i].car_out    = 1'b0;
            vectors[i].boat_close = 1'b0;
            vectors[i].boat_here  = 1'b0;
            vectors[i].fault_ack  = 1'b0;
            vectors[i].exp_state  = ST_O;
            vectors[i].exp_fault  = 1'b0;
            if (i < 9) begin
                vectors[i].car_in    = 1'b1;
                vectors[i].exp_count = CNT_W'((i + 1 > 7) ? 7 : i + 1);
                vectors[i].name      = "cnt_up_sat";
            end else if (i < 17) begin
                vectors[i].car_out   = 1'b1;
                vectors[i].exp_count = CNT_W'((15 - i < 0) ? 0 : 15 - i);
                vectors[i].name      = "cnt_down_sat";
            end else if (i < 20) begin
                vectors[i].car_in    = 1'b1;
                vectors[i].exp_count = CNT_W'(i - 16);
                vectors[i].name      = "cnt_to_3";
            end else begin
                vectors[i].car_in    = (i == 20);
                vectors[i].car_out   = (i == 20);
                vectors[i].exp_count = 3'd3;
                vectors[i].name      = (i == 20) ? "cnt_both_hold" : "cnt_idle_hold";
            end
        end

        rst_n           = 1'b0;
        bus.i_carIn     = 1'b0;
        bus.i_carOut    = 1'b0;
        bus.i_boatClose = 1'b0;
        bus.i_boatHere  = 1'b0;
        bus.i_faultAck  = 1'b0;
        #12;
        checkZero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] counter saturation table");
        for (int i = 0; i < 22; i++) begin
            applyStimulus(vectors[i].car_in, vectors[i].car_out, vectors[i].boat_close,
                          vectors[i].boat_here, vectors[i].fault_ack, vectors[i].exp_state,
                          vectors[i].exp_count, vectors[i].exp_fault, vectors[i].name);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 0, 0, ST_O, CNT_W'(2 - i), 0, "cnt_drain");
        end

        $display("[TB] empty bridge full cycle");
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(0, 0, 1, 0, 0,
                          (i <= 4) ? ST_W : (i == 5) ? ST_C : (i <= 8) ? ST_R : ST_U,
                          3'd0, 0, "cycle_raise");
        end
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, (i <= 3) ? ST_L : ST_O, 3'd0, 0, "cycle_lower");
        end

        $display("[TB] cars leave during clearance");
        countUp2();
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(0, 0, 0, 1, 0, (i <= 4) ? ST_W : ST_C, 3'd2, 0, "clr_enter");
        end
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 0, 0, 1, 0, ST_C, 3'd2, 0, "clr_wait");
        end
        applyStimulus(0, 1, 0, 1, 0, ST_C, 3'd1, 0, "clr_out1");
        applyStimulus(0, 1, 0, 1, 0, ST_C, 3'd0, 0, "clr_out2");
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 0, 0, 1, 0, (i <= 3) ? ST_R : ST_U, 3'd0, 0, "clr_raise");
        end
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, (i <= 3) ? ST_L : ST_O, 3'd0, 0, "clr_lower");
        end

        $display("[TB] clearance timeout and fault recovery");
        countUp2();
        for (int i = 1; i <= 14; i++) begin
            applyStimulus(0, 0, 0, 1, 0, (i <= 4) ? ST_W : ST_C, 3'd2, 0, "to_clear");
        end
        applyStimulus(0, 0, 0, 1, 0, ST_F, 3'd2, 1, "to_fault");
        applyStimulus(0, 0, 0, 1, 1, ST_F, 3'd2, 1, "ack_in_fault");
        applyStimulus(0, 1, 0, 1, 0, ST_F, 3'd1, 1, "fault_out1");
        applyStimulus(0, 1, 0, 1, 0, ST_F, 3'd0, 1, "fault_out2");
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 0, 0, 1, 0, (i <= 3) ? ST_R : ST_U, 3'd0, 1, "fault_raise");
        end
        applyStimulus(0, 0, 0, 1, 1, ST_U, 3'd0, 0, "ack_in_up");

        $display("[TB] request during lowering");
        applyStimulus(0, 0, 0, 0, 0, ST_L, 3'd0, 0, "low_start");
        applyStimulus(0, 0, 1, 0, 0, ST_L, 3'd0, 0, "low_req2");
        applyStimulus(0, 0, 1, 0, 0, ST_L, 3'd0, 0, "low_req3");
        applyStimulus(0, 0, 1, 0, 0, ST_O, 3'd0, 0, "low_open");
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(0, 0, 1, 0, 0, (i <= 4) ? ST_W : (i == 5) ? ST_C : ST_R,
                          3'd0, 0, "low_rewarn");
        end
        applyStimulus(1, 0, 1, 0, 0, ST_R, 3'd1, 0, "raise_car");

        $display("[TB] asynchronous reset during raise");
        #2;
        rst_n = 1'b0;
        #1;
        checkZero("async_reset_raise");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, ST_O, 3'd0, 0, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
